// File: rtl/riscv_pkg.sv
// Shared definitions for the program loader: bus width and loader FSM encodings.
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    S_LEN  = 3'd0,
    S_DATA = 3'd1,
    S_CHK  = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_e;

endpackage

// File: rtl/rom_loader_byte_to_word.sv
// Little-endian byte-to-word assembler. word_vld_o pulses combinationally with the
// 4th accepted byte; word_o is valid in that same cycle.
module byte_to_word
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rstn,
  input  logic            clr_i,
  input  logic            vld_i,
  input  logic [7:0]      byte_i,
  output logic [XLEN-1:0] word_o,
  output logic            word_vld_o
);

  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] buf_q, buf_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
      buf_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      buf_q <= buf_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    buf_d = buf_q;
    if (clr_i) begin
      cnt_d = '0;
      buf_d = '0;
    end else if (vld_i) begin
      cnt_d = cnt_q + 2'd1;
      unique case (cnt_q)
        2'd0:    buf_d[7:0]   = byte_i;
        2'd1:    buf_d[15:8]  = byte_i;
        2'd2:    buf_d[23:16] = byte_i;
        default: buf_d        = buf_q;
      endcase
    end
  end

  assign word_o     = {byte_i, buf_q};
  assign word_vld_o = vld_i && !clr_i && (cnt_q == 2'd3);

endmodule

// File: rtl/rom_loader.sv
// Byte-stream ROM loader: LEN, data words, optional XOR checksum; releases core reset on success.
// Checksum byte is present only when ROM_LOADER_CHKSUM_EN is defined.
module rom_loader
  import riscv_pkg::*;
#(
  parameter int              DEPTH_WORDS = 4096,
  parameter logic [XLEN-1:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [7:0]      rx_data,
  input  logic            rx_valid,
  output logic            rx_ready,
  input  logic            load_start,
  output logic            rom_we,
  output logic [XLEN-1:0] rom_waddr,
  output logic [XLEN-1:0] rom_wdata,
  output logic            core_rstn,
  output logic            load_done,
  output logic            load_err
);

`ifdef ROM_LOADER_CHKSUM_EN
  localparam state_e S_FIN = S_CHK;
`else
  localparam state_e S_FIN = S_DONE;
`endif

  state_e          state_q, state_d;
  logic [XLEN-1:0] len_q, len_d;
  logic [XLEN-1:0] widx_q, widx_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] waddr_q, waddr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic            accept;
  logic            w_vld;
  logic [XLEN-1:0] word;

  // A byte arriving with load_start is dropped.
  assign accept = rx_valid && rx_ready && !load_start;

  byte_to_word u_b2w (
    .clk       (clk),
    .rstn      (rstn),
    .clr_i     (load_start),
    .vld_i     (accept && (state_q == S_LEN || state_q == S_DATA)),
    .byte_i    (rx_data),
    .word_o    (word),
    .word_vld_o(w_vld)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_LEN;
      len_q   <= '0;
      widx_q  <= '0;
      we_q    <= 1'b0;
      waddr_q <= BASE_ADDR;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      widx_q  <= widx_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

`ifdef ROM_LOADER_CHKSUM_EN
  logic [7:0] chk_q, chk_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) chk_q <= '0;
    else       chk_q <= chk_d;
  end

  always_comb begin
    chk_d = chk_q;
    if (load_start)                        chk_d = '0;
    else if (accept && state_q == S_DATA)  chk_d = chk_q ^ rx_data;
  end
`endif

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    widx_d  = widx_q;
    if (load_start) begin
      state_d = S_LEN;
      len_d   = '0;
      widx_d  = '0;
    end else begin
      unique case (state_q)
        S_LEN: if (w_vld) begin
          len_d = word;
          if (word == '0)                     state_d = S_FIN;
          else if (word > XLEN'(DEPTH_WORDS)) state_d = S_ERR;
          else                                state_d = S_DATA;
        end
        S_DATA: if (w_vld) begin
          widx_d = widx_q + 32'd1;
          if (widx_q + 32'd1 == len_q) state_d = S_FIN;
        end
`ifdef ROM_LOADER_CHKSUM_EN
        S_CHK: if (accept) state_d = (rx_data == chk_q) ? S_DONE : S_ERR;
`endif
        default: state_d = state_q;
      endcase
    end
  end

  // Write port: registered, one-cycle strobe after each word's 4th byte.
  always_comb begin
    we_d    = (state_q == S_DATA) && w_vld;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (we_d) begin
      waddr_d = BASE_ADDR + (widx_q << 2);
      wdata_d = word;
    end
  end

  // Hold off completion while the last word is still being written.
  always_comb begin
    rx_ready  = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CHK);
    load_done = (state_q == S_DONE) && !we_q;
    core_rstn = load_done;
    load_err  = (state_q == S_ERR);
  end

  assign rom_we    = we_q;
  assign rom_waddr = waddr_q;
  assign rom_wdata = wdata_q;

endmodule

// File: tb/tb_rom_loader.sv
// Randomized bench for rom_loader against a frame-level reference model.
module tb_rom_loader;

  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h0000_0000;
`ifdef ROM_LOADER_CHKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic        clk, rstn, rx_valid, rx_ready, load_start;
  logic [7:0]  rx_data;
  logic        rom_we, core_rstn, load_done, load_err;
  logic [31:0] rom_waddr, rom_wdata;

  rom_loader #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rstn(rstn), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .load_start(load_start), .rom_we(rom_we), .rom_waddr(rom_waddr), .rom_wdata(rom_wdata),
    .core_rstn(core_rstn), .load_done(load_done), .load_err(load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Write capture and core_rstn/load_done consistency monitor.
  logic [31:0] cap_a[$], cap_d[$];
  int bad_rst = 0;
  always @(negedge clk) if (rstn) begin
    if (rom_we) begin cap_a.push_back(rom_waddr); cap_d.push_back(rom_wdata); end
    if (core_rstn !== load_done) bad_rst++;
  end

  logic [31:0] wq[$];

  task automatic check_reset(input string tag);
    check({tag, "_rx_ready"}, rx_ready, 1);
    check({tag, "_rom_we"},   rom_we, 0);
    check({tag, "_waddr"},    rom_waddr, BASE);
    check({tag, "_wdata"},    rom_wdata, 0);
    check({tag, "_core_rstn"},core_rstn, 0);
    check({tag, "_done"},     load_done, 0);
    check({tag, "_err"},      load_err, 0);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gappy);
    if (gappy) begin
      rx_valid = 1'b0; rx_data = 8'($urandom);
      @(posedge clk); #1;
    end
    rx_valid = 1'b1; rx_data = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  // Model: writes go to BASE+4*i; error if LEN too large or checksum differs from data XOR.
  task automatic run_frame(input string name, input logic [31:0] len, input bit gappy,
                           input bit force_chk, input logic [7:0] chk_val);
    logic [7:0] x, sent;
    bit exp_err;
    int lat, cyc, nexp;
    load_start = 1'b1; @(posedge clk); #1; load_start = 1'b0;
    cap_a.delete(); cap_d.delete(); bad_rst = 0;
    check({name, "_rearm_core_rstn"}, core_rstn, 0);
    check({name, "_rearm_ready"}, rx_ready, 1);
    for (int i = 0; i < 4; i++) send_byte(len[8*i +: 8], gappy);
    if (len > 32'(DEPTH)) begin
      exp_err = 1'b1; lat = 1; nexp = 0;
    end else begin
      nexp = int'(len);
      x = 8'h00;
      for (int i = 0; i < nexp; i++)
        for (int k = 0; k < 4; k++) begin
          x ^= wq[i][8*k +: 8];
          send_byte(wq[i][8*k +: 8], gappy);
        end
      sent = force_chk ? chk_val : x;
      if (CHK_EN) begin
        send_byte(sent, gappy);
        exp_err = (sent != x); lat = 1;
      end else begin
        exp_err = 1'b0; lat = (nexp == 0) ? 1 : 2;
      end
    end
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!(load_done || load_err) && cyc < 10);
    check({name, "_latency"},   cyc, lat);
    check({name, "_done"},      load_done, !exp_err);
    check({name, "_err"},       load_err, exp_err);
    check({name, "_core_rstn"}, core_rstn, !exp_err);
    check({name, "_rx_ready"},  rx_ready, 0);
    check({name, "_nwrites"},   cap_a.size(), nexp);
    for (int i = 0; i < nexp && i < cap_a.size(); i++) begin
      check($sformatf("%s_addr%0d", name, i), cap_a[i], BASE + 32'(4*i));
      check($sformatf("%s_data%0d", name, i), cap_d[i], wq[i]);
    end
    check({name, "_rst_vs_done"}, bad_rst, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] l;
    rstn = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; load_start = 1'b0;
    #12;
    check_reset("reset");
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;

    wq = '{32'h0000_0013, 32'h0010_0093};
    run_frame("plan_len2", 32'd2, 1'b0, 1'b1, 8'h90);
    run_frame("plan_gappy", 32'd2, 1'b1, 1'b1, 8'h90);

    wq = '{32'hDEAD_BEEF};
    run_frame("bad_chk", 32'd1, 1'b0, 1'b1, 8'h00);

    run_frame("len_over", 32'(DEPTH + 1), 1'b0, 1'b0, 8'h00);
    run_frame("len_max32", 32'hFFFF_FFFF, 1'b1, 1'b0, 8'h00);
    run_frame("len_zero", 32'd0, 1'b0, 1'b1, 8'h00);

    // Reset asserted mid-frame, then a clean re-load.
    load_start = 1'b1; @(posedge clk); #1; load_start = 1'b0;
    for (int i = 0; i < 6; i++) send_byte((i == 0) ? 8'h01 : 8'($urandom), 1'b0);
    #2 rstn = 1'b0;
    #1 check_reset("midreset");
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;
    wq = '{32'($urandom)};
    run_frame("after_reset", 32'd1, 1'b0, 1'b0, 8'h00);

    wq.delete();
    for (int i = 0; i < DEPTH; i++) wq.push_back(32'($urandom));
    run_frame("len_depth", 32'(DEPTH), 1'b0, 1'b0, 8'h00);

    for (int t = 0; t < 8; t++) begin
      l = 32'($urandom_range(0, DEPTH));
      wq.delete();
      for (int i = 0; i < int'(l); i++) wq.push_back(32'($urandom));
      run_frame($sformatf("rand%0d", t), l, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0), 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rom_loader.md
# rom_loader

Synthesizable program loader that fills the instruction ROM from a byte stream, replacing the simulation-only memory preload. Sits between a byte-stream source (UART receiver or debug port) and the ROM write port of `riscv_soc`. Holds the core in reset while loading, then releases it so execution starts at `BASE_ADDR`.

## Interface
Parameters:
- `DEPTH_WORDS`, 4096: ROM capacity in 32-bit words; the length field may not exceed this.
- `BASE_ADDR`, 32'h0000_0000: byte address of the first word written.

Ports:
- `clk`  in  1  system clock; every flop uses its rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `rx_data`  in  8  stream byte.
- `rx_valid`  in  1  `rx_data` is valid.
- `rx_ready`  out  1  loader accepts a byte this cycle.
- `load_start`  in  1  single-cycle pulse that re-arms the loader.
- `rom_we`  out  1  ROM write strobe, one cycle per word.
- `rom_waddr`  out  32  ROM byte address.
- `rom_wdata`  out  32  ROM write data.
- `core_rstn`  out  1  active-low reset to the core.
- `load_done`  out  1  load completed successfully.
- `load_err`  out  1  load aborted.

## Operation
- Frame format, all fields little-endian:
  - 4-byte `LEN`, the word count N.
  - N×4 data bytes.
  - 1 checksum byte (XOR of all data bytes; length bytes excluded).
- A byte is accepted when `rx_valid && rx_ready`.
- FSM states:
  - `S_LEN`: collect 4 bytes. If LEN == 0, go to `S_CHK`. If LEN > `DEPTH_WORDS`, go to `S_ERR`. Otherwise go to `S_DATA`.
  - `S_DATA`: a 2-bit byte counter assembles each word. On the 4th byte, register the word and a one-cycle `rom_we`. Word counter increments; after word N, go to `S_CHK`.
  - `S_CHK`: accept 1 byte. A match with the running XOR goes to `S_DONE`; a mismatch goes to `S_ERR`.
  - `S_DONE`: `rx_ready`=0, `core_rstn`=1, `load_done`=1.
  - `S_ERR`: `rx_ready`=0, `core_rstn`=0, `load_err`=1.
- `rom_waddr` = `BASE_ADDR` + 4×word_index, so the first word goes to `BASE_ADDR`. Width is 32 bits; no wrap, because LEN is capped.
- `load_start` in any state: clear the counters and XOR, and go to `S_LEN`. `core_rstn` goes to 0 the next cycle. Any byte presented in the same cycle is dropped.
- `core_rstn` = 1 only in `S_DONE`.

## Timing
- Reset values:
  - state = `S_LEN`
  - `rx_ready`=1 (combinational from state)
  - `rom_we`=0, `rom_waddr`=`BASE_ADDR`, `rom_wdata`=0
  - `core_rstn`=0, `load_done`=0, `load_err`=0
- `rx_ready` is combinational from state: 1 in `S_LEN`, `S_DATA` and `S_CHK`.
- Write latency: `rom_we`, `rom_waddr` and `rom_wdata` are registered. They are valid for exactly one cycle, the cycle after the 4th byte of a word is accepted.
- Back-to-back bytes at one per cycle are sustained; there are no bubbles.
- Gaps in `rx_valid` hold all state unchanged.
- `load_done` and `core_rstn` rise in the cycle after the checksum byte is accepted. The last `rom_we` precedes this by at least 1 cycle.
- `load_err` rises in the cycle after the offending byte (4th LEN byte or checksum byte).
- `rstn` asserted mid-load returns to reset values immediately (asynchronous). Partially written ROM contents are left as-is.

## Configuration
- `ROM_LOADER_CHKSUM_EN` defined:
  - checksum byte expected in the frame;
  - mismatch goes to `S_ERR`.
- `ROM_LOADER_CHKSUM_EN` undefined:
  - there is no checksum byte and no XOR register;
  - after word N, or immediately for LEN == 0, go directly to `S_DONE`;
  - `load_err` is raised only for LEN > `DEPTH_WORDS`.

## Structure
- Shared package `riscv_pkg` holds:
  - FSM state encodings `S_LEN`, `S_DATA`, `S_CHK`, `S_DONE`, `S_ERR`;
  - the 32-bit bus width constant.
- One sub-module, `byte_to_word`: collects 4 accepted bytes little-endian and emits a word-valid pulse. It is reused for the LEN field and for each data word.

## Test plan
- LEN=2, data 13 00 00 00 / 93 00 10 00, checksum 0x90 -> `rom_we` at addr 0x0 with 0x00000013, then at 0x4 with 0x00100093; `load_done`=1, `core_rstn`=1.
- Same frame with `rx_valid` toggled every other cycle -> identical writes and result; no byte is lost or duplicated.
- LEN=1, data EF BE AD DE, checksum 0x00 (correct value is 0x22) -> one write of 0xDEADBEEF; `load_err`=1, `core_rstn` stays 0.
- LEN=`DEPTH_WORDS`+1 -> `load_err`=1 one cycle after the 4th length byte, no `rom_we`, `rx_ready`=0.
- LEN=0, checksum 0x00 -> `load_done` with zero writes.
- `rstn` pulsed low after 6 bytes, then `load_start` pulsed, then a full LEN=1 frame -> `core_rstn`=0 throughout, single write at 0x0, `load_done`=1.
